// File: rtl/i2s_transmitter_if.sv
// Sample handshake and I2S line bundle for i2s_transmitter.
// master: audio pipeline / bench side, slave: the transmitter.
interface i2s_transmitter_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] sample_left;
  logic [DATA_WIDTH-1:0] sample_right;
  logic                  sample_valid;
  logic                  sample_ready;
  logic                  i2s_sck;
  logic                  i2s_ws;
  logic                  i2s_sd;
  logic                  underrun;
  logic                  frame_start;

  modport master (
    output sample_left,
    output sample_right,
    output sample_valid,
    input  sample_ready,
    input  i2s_sck,
    input  i2s_ws,
    input  i2s_sd,
    input  underrun,
    input  frame_start
  );

  modport slave (
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    output sample_ready,
    output i2s_sck,
    output i2s_ws,
    output i2s_sd,
    output underrun,
    output frame_start
  );
endinterface

// File: rtl/i2s_transmitter.sv
// I2S controller-transmitter: generates SCK/WS from clk_in and shifts a
// stereo pair out on SD, Philips framing, 64 SCK per frame, 32-bit slots.
// A one-entry holding buffer decouples the pipeline from the frame timing.
// Optional build macro I2S_TX_HOLD_LAST_EN: an underrun frame repeats the
// last pair loaded from the buffer instead of sending silence.
module i2s_transmitter #(
  parameter int SCK_DIV    = 16,
  parameter int DATA_WIDTH = 24
) (
  input logic               clk_in,
  input logic               rst_in,
  i2s_transmitter_if.slave  bus
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam int PAD = 32 - DATA_WIDTH;

  logic [DIV_W-1:0]      r_div_cnt;
  logic                  r_sck;
  logic                  r_ws;
  logic                  r_sd;
  logic [5:0]            r_k;
  logic [63:0]           r_shift;
  logic [DATA_WIDTH-1:0] r_buf_left;
  logic [DATA_WIDTH-1:0] r_buf_right;
  logic                  r_buf_full;
  logic                  r_underrun;
  logic                  r_frame_start;

  logic                  w_div_last;
  logic                  w_fe;
  logic [5:0]            w_k_next;
  logic                  w_load;
  logic                  w_write;
  logic [63:0]           w_load_word;

`ifdef I2S_TX_HOLD_LAST_EN
  logic [63:0]           r_last_word;
`endif

  // Left-justify a sample in its 32-bit slot, zero padding below the LSB.
  function automatic logic [31:0] to_slot(input logic [DATA_WIDTH-1:0] s);
    return 32'(s) << PAD;
  endfunction

  assign w_div_last = (r_div_cnt == DIV_LAST);
  // Falling SCK edge: every serial register updates together with sck going low.
  assign w_fe       = r_sck && w_div_last;
  assign w_k_next   = r_k + 6'd1;
  assign w_load     = w_fe && (w_k_next == 6'd0);
  // Buffer state is the registered value, so a write on a load clock is held
  // for the following frame rather than forwarded into this one.
  assign w_write    = bus.sample_valid && !r_buf_full;

  // Select the word loaded into the shifter at the start of a frame.
  always_comb begin
    w_load_word = 64'd0;
    if (r_buf_full) begin
      w_load_word = {to_slot(r_buf_left), to_slot(r_buf_right)};
    end
`ifdef I2S_TX_HOLD_LAST_EN
    else begin
      w_load_word = r_last_word;
    end
`endif
  end

  // SCK divider: toggle every SCK_DIV clocks, first rise SCK_DIV clocks after reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (w_div_last) begin
      r_div_cnt <= '0;
      r_sck     <= ~r_sck;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Frame position, word select and shifter, all advanced on the falling edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_k     <= 6'd63;
      r_ws    <= 1'b0;
      r_shift <= 64'd0;
      r_sd    <= 1'b0;
    end else if (w_fe) begin
      r_k  <= w_k_next;
      // WS leads the slot by one bit: high from k=31 through k=62.
      r_ws <= (w_k_next >= 6'd31) && (w_k_next <= 6'd62);
      if (w_load) begin
        r_shift <= w_load_word;
        r_sd    <= w_load_word[63];
      end else begin
        r_shift <= {r_shift[62:0], 1'b0};
        r_sd    <= r_shift[62];
      end
    end
  end

  // Holding buffer: captured on handshake, emptied by a frame load.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_buf_full  <= 1'b0;
      r_buf_left  <= '0;
      r_buf_right <= '0;
    end else if (w_load && r_buf_full) begin
      r_buf_full <= 1'b0;
    end else if (w_write) begin
      r_buf_full  <= 1'b1;
      r_buf_left  <= bus.sample_left;
      r_buf_right <= bus.sample_right;
    end
  end

  // One-clock status pulses marking each frame load.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_buf_full;
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  // Remember the most recent pair taken from the buffer for underrun repeats.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_last_word <= 64'd0;
    end else if (w_load && r_buf_full) begin
      r_last_word <= w_load_word;
    end
  end
`endif

  assign bus.sample_ready = !r_buf_full;
  assign bus.i2s_sck      = r_sck;
  assign bus.i2s_ws       = r_ws;
  assign bus.i2s_sd       = r_sd;
  assign bus.underrun     = r_underrun;
  assign bus.frame_start  = r_frame_start;

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- I2S controller-transmitter: generates SCK/WS and serializes stereo PCM samples onto SD for an external I2S DAC/amplifier.
- Counterpart of the `microphones` I2S receiver, in the same 100 MHz `clk_in` domain and with the same Philips I2S framing (64 SCK per frame, 32-bit slots, WS low = left).
- Audio pipeline pushes one stereo sample pair per frame through a valid/ready port into a one-entry holding buffer.

Parameters:
- SCK_DIV, 16: `clk_in` cycles per SCK half-period. SCK period = 2*SCK_DIV clocks. Legal values are >= 2.
- DATA_WIDTH, 24: sample width, legal range 1..32. Each sample is MSB-first and zero-padded to a 32-bit slot.

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  asynchronous, active-high reset
- sample_left  input  DATA_WIDTH  left sample, two's complement
- sample_right  input  DATA_WIDTH  right sample, two's complement
- sample_valid  input  1  sample pair present
- sample_ready  output  1  holding buffer empty, pair accepted when valid&&ready
- i2s_sck  output  1  serial bit clock
- i2s_ws  output  1  word select (0 = left, 1 = right)
- i2s_sd  output  1  serial data
- underrun  output  1  one-clk pulse: frame started with holding buffer empty
- frame_start  output  1  one-clk pulse: new frame loaded into shifter

Behaviour:
- Reset (asynchronous, all registers):
  - i2s_sck=0, i2s_ws=0, i2s_sd=0, underrun=0, frame_start=0, sample_ready=1.
  - div_cnt=0, bit index k=63, shifter=0, buffer empty.
- Divider:
  - div_cnt counts 0..SCK_DIV-1.
  - On the clock where div_cnt==SCK_DIV-1: i2s_sck toggles and div_cnt returns to 0.
  - The first SCK rising edge occurs SCK_DIV clocks after reset release.
- Falling-edge event (FE): the clock on which sck==1 and div_cnt==SCK_DIV-1. All serial state updates on FE, registered together with sck going low.
- Frame counter: k advances on each FE, wrapping 63->0.
- Word select (standard I2S one-bit lead):
  - i2s_ws=1 for k in 31..62.
  - i2s_ws=0 for k=63 and k in 0..30.
- Shifter (64 bits):
  - On FE with new k==0, load the shifter as {left slot, right slot}.
  - Slot = sample << (32-DATA_WIDTH).
  - On other FEs, shift left by one.
  - i2s_sd = shifter MSB, registered on FE.
  - Result: left MSB is driven during k=0, right MSB during k=32.
- Buffer and handshake:
  - sample_ready = !buffer_full.
  - On valid&&ready, both samples are captured and buffer_full=1.
- Load at k==0:
  - If buffer_full: load from the buffer, clear buffer_full, pulse frame_start.
  - If empty: load silence (all zeros), pulse frame_start and underrun.
- Simultaneous write and load:
  - The load decision uses buffer_full as registered before that clock.
  - Empty buffer + write on a load clock: underrun, and the written pair is held for the next frame.
  - Full buffer on a load clock: sample_ready=0, so no write can occur that clock.
- Latency: a pair accepted before a frame's load FE appears on SD starting at that FE. SD transitions are always on SCK falling edges, so the receiver samples on rising edges.
- Sample values: no width arithmetic beyond the padding. Signed samples are passed through bit-exact.
- Reset mid-frame:
  - Outputs return to reset values immediately (asynchronous) and the buffer is cleared.
  - After release, the next frame begins at the first FE with k=0.
- Idle: SCK and WS run continuously after reset; an empty buffer sends silence frames, each with an underrun pulse.

Optional Feature:
- Macro: I2S_TX_HOLD_LAST_EN.
- Defined: on underrun, the shifter reloads the last successfully loaded pair (zeros if none since reset) instead of silence. The underrun pulse is still generated.
- Undefined: underrun frames transmit all zeros.

Test Plan:
- Reset values and clock: hold rst_in, then release with SCK_DIV=4 -> sck=0, ws=0, sd=0, ready=1 during reset; sck period 8 clocks; first rise 4 clocks after release; ws toggles every 32 SCK; ws rises 1 SCK before the right slot MSB.
- Single frame: DATA_WIDTH=24, push left=0x800001, right=0x7FFFFF before first load -> SD bits sampled on SCK rising edges reconstruct left slot 0x80000100 and right slot 0x7FFFFF00; frame_start pulses once; no underrun.
- Backpressure: push two pairs back-to-back -> second pair held with ready=0 until next k==0 load; ready returns to 1 the clock after the load; both frames transmitted in order.
- Underrun: no push for one frame -> underrun pulses once at load; SD all zeros for 64 SCK. With I2S_TX_HOLD_LAST_EN, SD repeats previous pair 0x123456/0xABCDEF.
- Write on load clock: assert valid exactly on the empty-buffer load FE -> underrun pulses; pair transmitted in the following frame.
- Reset mid-frame: assert rst_in at k=40 -> outputs zero within the same clock without waiting for an edge; buffer cleared; after release, left MSB appears at the first FE.
